// File: rtl/mem_access_stage.sv
// MEM pipeline stage: multi-cycle data-memory access FSM feeding the MEM/WB register.
// Optional MEM_MISALIGN_CHECK_EN rejects memory ops whose byte address is not word aligned.
module mem_access_stage #(
    parameter int ACCESS_LAT = 2,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_EN,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALURes,
    input  logic [31:0] STVal,
    input  logic [4:0]  dest,
    input  logic        Zero,
    input  logic        branch,
    output logic        freeze,
    output logic        PCSrc,
    output logic        WB_WB_EN,
    output logic        WB_MEM_R_EN,
    output logic [31:0] WB_ALURes,
    output logic [31:0] WB_MemData,
    output logic [4:0]  WB_dest,
    output logic        misalign_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        opWbEn_q, opRd_q, opWr_q;
    logic [31:0] opAddr_q, opStVal_q;
    logic [4:0]  opDest_q;
    logic [31:0] loadData_q;
    logic        wbWbEn_q, wbMemREn_q, misalignErr_q;
    logic [31:0] wbAluRes_q, wbMemData_q;
    logic [4:0]  wbDest_q;

    logic [31:0] mem [0:(2**DEPTH_LOG2)-1];

    logic                  memOp;
    logic                  misaligned;
    logic                  accessEdge;
    logic [DEPTH_LOG2-1:0] wordAddr;

    assign memOp = MEM_R_EN | MEM_W_EN;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = memOp && (ALURes[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Address bits above the memory depth are dropped, so accesses wrap around.
    assign wordAddr   = opAddr_q[DEPTH_LOG2+1:2];
    assign accessEdge = (state_q == BUSY) && (cnt_q == 4'd0);

    assign freeze = ~rst & (((state_q == IDLE) && memOp && !misaligned) || (state_q == BUSY));
    assign PCSrc  = ~rst & branch & Zero & ~freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            opWbEn_q      <= 1'b0;
            opRd_q        <= 1'b0;
            opWr_q        <= 1'b0;
            opAddr_q      <= 32'd0;
            opStVal_q     <= 32'd0;
            opDest_q      <= 5'd0;
            loadData_q    <= 32'd0;
            wbWbEn_q      <= 1'b0;
            wbMemREn_q    <= 1'b0;
            wbAluRes_q    <= 32'd0;
            wbMemData_q   <= 32'd0;
            wbDest_q      <= 5'd0;
            misalignErr_q <= 1'b0;
        end else begin
            misalignErr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (memOp && misaligned) begin
                        wbWbEn_q      <= 1'b0;
                        wbMemREn_q    <= 1'b0;
                        misalignErr_q <= 1'b1;
                    end else if (memOp) begin
                        opWbEn_q   <= WB_EN;
                        opRd_q     <= MEM_R_EN;
                        opWr_q     <= MEM_W_EN;
                        opAddr_q   <= ALURes;
                        opStVal_q  <= STVal;
                        opDest_q   <= dest;
                        wbWbEn_q   <= 1'b0;
                        wbMemREn_q <= 1'b0;
                        cnt_q      <= 4'(ACCESS_LAT - 1);
                        state_q    <= BUSY;
                    end else begin
                        wbWbEn_q   <= WB_EN;
                        wbMemREn_q <= 1'b0;
                        wbAluRes_q <= ALURes;
                        wbDest_q   <= dest;
                    end
                end
                BUSY: begin
                    wbWbEn_q   <= 1'b0;
                    wbMemREn_q <= 1'b0;
                    if (cnt_q == 4'd0) begin
                        // Captured before the same-edge store lands: read-before-write.
                        if (opRd_q) begin
                            loadData_q <= mem[wordAddr];
                        end
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    wbWbEn_q   <= opWbEn_q;
                    wbMemREn_q <= opRd_q;
                    wbAluRes_q <= opAddr_q;
                    wbDest_q   <= opDest_q;
                    if (opRd_q) begin
                        wbMemData_q <= loadData_q;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory has no reset; a reset on the access edge suppresses the store.
    always_ff @(posedge clk) begin
        if (!rst && accessEdge && opWr_q) begin
            mem[wordAddr] <= opStVal_q;
        end
    end

    assign WB_WB_EN     = wbWbEn_q;
    assign WB_MEM_R_EN  = wbMemREn_q;
    assign WB_ALURes    = wbAluRes_q;
    assign WB_MemData   = wbMemData_q;
    assign WB_dest      = wbDest_q;
    assign misalign_err = misalignErr_q;

endmodule
